// File: rtl/tx_lane_swizzler_pkg.sv
// Shared TX/RX lane package: geometry of the lane/chunk datapath and mask helpers.
package tx_lane_swizzler_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned CHUNK_W = 48;
  localparam int unsigned DEPTH   = 2 * LANES;
  localparam int unsigned WORD_W  = LANES * CHUNK_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned NCNT_W  = $clog2(LANES + 1);
  localparam int unsigned LIDX_W  = $clog2(LANES);

  typedef logic [CHUNK_W-1:0] chunk_t;
  typedef logic [LANES-1:0]   mask_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [NCNT_W-1:0]  ncnt_t;
  typedef logic [LIDX_W-1:0]  lidx_t;

  function automatic ncnt_t popcount(input mask_t m);
    ncnt_t c;
    c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      c = c + ncnt_t'(m[i]);
    end
    return c;
  endfunction

  // Index of the n-th set bit (n counted from 0, ascending); 0 when absent.
  function automatic lidx_t nth_set_bit(input mask_t m, input ncnt_t n);
    ncnt_t seen;
    lidx_t idx;
    seen = '0;
    idx  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (m[i]) begin
        if (seen == n) idx = lidx_t'(i);
        seen = seen + 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tx_chunk_fifo.sv
// Circular chunk queue: pushes a whole word (LANES chunks), pops 0..LANES head chunks.
module tx_chunk_fifo
  import tx_lane_swizzler_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_push,
  input  logic [WORD_W-1:0]       i_push_data,
  input  ncnt_t                   i_pop_n,
  output chunk_t [LANES-1:0]      o_head,
  output cnt_t                    o_cnt,
  output logic                    o_overflow
);

  typedef logic [CNT_W:0] wcnt_t;

  chunk_t r_mem [DEPTH];
  ptr_t   r_head;
  ptr_t   r_tail;
  cnt_t   r_cnt;

  wcnt_t  w_cnt_pop;
  wcnt_t  w_cnt_push;
  logic   w_push_ok;

  always_comb begin
    w_cnt_pop  = {1'b0, r_cnt} - wcnt_t'(i_pop_n);
    w_cnt_push = w_cnt_pop + wcnt_t'(LANES);
    o_overflow = i_push && (w_cnt_push > wcnt_t'(DEPTH));
    w_push_ok  = i_push && !o_overflow;
    for (int unsigned k = 0; k < LANES; k++) begin
      o_head[k] = r_mem[r_head + ptr_t'(k)];
    end
  end

  assign o_cnt = r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      r_head <= r_head + ptr_t'(i_pop_n);
      if (w_push_ok) begin
        r_tail <= r_tail + ptr_t'(LANES);
        r_cnt  <= cnt_t'(w_cnt_push);
      end else begin
        r_cnt  <= cnt_t'(w_cnt_pop);
      end
    end
  end

  // Storage needs no reset: head/tail/count define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        r_mem[r_tail + ptr_t'(k)] <= i_push_data[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

endmodule

// File: rtl/tx_lane_swizzler.sv
// Splits 192-bit words into 48-bit chunks and spreads them over the enabled TX lanes.
module tx_lane_swizzler
  import tx_lane_swizzler_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_enable,
  input  logic [WORD_W-1:0]       in_txdata,
  input  logic                    in_txdata_valid,
  output logic                    out_idle,
  input  logic [LANES-1:0]        lane_mask,
  output logic [WORD_W-1:0]       lane_data,
  output logic [LANES-1:0]        lane_valid,
  output logic [CNT_W-1:0]        residue_cnt,
  output logic                    overflow_err
);

  mask_t             r_act_mask;
  logic [WORD_W-1:0] r_lane_data;
  mask_t             r_lane_valid;
  logic              r_overflow_err;

  ncnt_t             w_n_act;
  cnt_t              w_cnt;
  logic              w_accept;
  logic              w_emit;
  ncnt_t             w_pop_n;
  logic              w_fifo_ovf;
  chunk_t [LANES-1:0] w_head;
  chunk_t [LANES-1:0] w_lane_sel;
  mask_t             w_below;

  assign w_n_act  = popcount(r_act_mask);
  assign out_idle = in_enable && (r_act_mask != '0) && (w_cnt <= cnt_t'(DEPTH - LANES));
  assign w_accept = in_txdata_valid && out_idle;
  // Uses the pre-edge count, so chunks accepted this edge are never emitted this edge.
  assign w_emit   = in_enable && (w_n_act != '0) && (w_cnt >= cnt_t'(w_n_act));
  assign w_pop_n  = w_emit ? w_n_act : '0;

  tx_chunk_fifo u_fifo (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_push      (w_accept),
    .i_push_data (in_txdata),
    .i_pop_n     (w_pop_n),
    .o_head      (w_head),
    .o_cnt       (w_cnt),
    .o_overflow  (w_fifo_ovf)
  );

  // An active lane takes the head chunk whose index is the number of active lanes below it.
  always_comb begin
    w_below = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_lane_sel[i] = w_head[lidx_t'(popcount(r_act_mask & w_below))];
      w_below[i]    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_mask     <= '0;
      r_lane_data    <= '0;
      r_lane_valid   <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (in_enable && (w_cnt == '0)) r_act_mask <= lane_mask;
      if (w_emit) begin
        r_lane_valid <= r_act_mask;
        for (int unsigned i = 0; i < LANES; i++) begin
          if (r_act_mask[i]) r_lane_data[i*CHUNK_W +: CHUNK_W] <= w_lane_sel[i];
        end
      end else begin
        r_lane_valid <= '0;
      end
      if (w_fifo_ovf) r_overflow_err <= 1'b1;
    end
  end

  assign lane_data    = r_lane_data;
  assign lane_valid   = r_lane_valid;
  assign residue_cnt  = w_cnt;
  assign overflow_err = r_overflow_err;

endmodule

// File: tb/tb_tx_lane_swizzler.sv
// Bench for tx_lane_swizzler: queue-based reference model plus directed literal checks.
module tb_tx_lane_swizzler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_enable = 1'b1;
  logic [191:0] in_txdata = '0;
  logic         in_txdata_valid = 1'b0;
  logic         out_idle;
  logic [3:0]   lane_mask = 4'h0;
  logic [191:0] lane_data;
  logic [3:0]   lane_valid;
  logic [3:0]   residue_cnt;
  logic         overflow_err;

  int n_vec  = 0;
  int n_miss = 0;

  tx_lane_swizzler dut (
    .clk             (clk),
    .reset           (reset),
    .in_enable       (in_enable),
    .in_txdata       (in_txdata),
    .in_txdata_valid (in_txdata_valid),
    .out_idle        (out_idle),
    .lane_mask       (lane_mask),
    .lane_data       (lane_data),
    .lane_valid      (lane_valid),
    .residue_cnt     (residue_cnt),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: chunk queue, latched lane set, expected lane outputs.
  logic [47:0] m_q[$];
  logic [3:0]  m_act = 4'h0;
  logic [3:0]  m_valid = 4'h0;
  logic [47:0] m_data[4] = '{default: 48'h0};
  logic        m_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    int pre;
    int n;
    bit idle;
    if (reset) begin
      m_q.delete();
      m_act   = 4'h0;
      m_valid = 4'h0;
      for (int i = 0; i < 4; i++) m_data[i] = 48'h0;
      m_ovf   = 1'b0;
    end else if (in_enable) begin
      pre  = m_q.size();
      n    = $countones(m_act);
      idle = (m_act != 4'h0) && (pre <= 4);
      if (n > 0 && pre >= n) begin
        m_valid = m_act;
        for (int i = 0; i < 4; i++) if (m_act[i]) m_data[i] = m_q.pop_front();
      end else begin
        m_valid = 4'h0;
      end
      if (in_txdata_valid && idle)
        for (int k = 0; k < 4; k++) m_q.push_back(in_txdata[k*48 +: 48]);
      if (m_q.size() > 8) m_ovf = 1'b1;
      if (pre == 0) m_act = lane_mask;
    end else begin
      m_valid = 4'h0;
    end
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc lane_valid", lane_valid, m_valid);
      chk("cyc lane_data", lane_data, {m_data[3], m_data[2], m_data[1], m_data[0]});
      chk("cyc residue_cnt", residue_cnt, m_q.size());
      chk("cyc out_idle", out_idle, in_enable && (m_act != 4'h0) && (m_q.size() <= 4));
      chk("cyc overflow_err", overflow_err, m_ovf);
    end
  end

  function automatic logic [47:0] ch(input logic [7:0] tag, input int k);
    return {32'd0, tag, 8'(k)};
  endfunction

  function automatic logic [191:0] mk(input logic [7:0] tag);
    logic [191:0] r;
    for (int k = 0; k < 4; k++) r[k*48 +: 48] = ch(tag, k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [191:0] w);
    bit acc;
    in_txdata       = w;
    in_txdata_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = out_idle;
      step();
    end
    in_txdata_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_word: word %h got no out_idle within 50 cycles, required acceptance", w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset lane_valid", lane_valid, 4'h0);
    chk("reset lane_data", lane_data, 192'h0);
    chk("reset residue", residue_cnt, 4'd0);
    chk("reset out_idle", out_idle, 1'b0);
    chk("reset overflow", overflow_err, 1'b0);
    reset = 1'b0;
    step();
    chk("mask0 out_idle", out_idle, 1'b0);

    // All four lanes: one full word per edge.
    lane_mask = 4'hF;
    step();
    chk("t1 out_idle", out_idle, 1'b1);
    send_word(mk(8'hD1));
    send_word(mk(8'hD2));
    chk("t1 valid", lane_valid, 4'hF);
    chk("t1 data D1", lane_data, mk(8'hD1));
    send_word(mk(8'hD3));
    chk("t1 data D2", lane_data, mk(8'hD2));
    chk("t1 idle", out_idle, 1'b1);
    chk("t1 residue", residue_cnt, 4'd4);
    step();
    chk("t1 data D3", lane_data, mk(8'hD3));
    chk("t1 residue0", residue_cnt, 4'd0);
    step();
    chk("t1 valid off", lane_valid, 4'h0);

    // Three lanes 0,1,3: residue carried across words.
    lane_mask = 4'b1011;
    step();
    send_word(mk(8'hA0));
    chk("t2 residue A", residue_cnt, 4'd4);
    send_word(mk(8'hB0));
    chk("t2 valid1", lane_valid, 4'b1011);
    chk("t2 lane0 A0", lane_data[47:0], 48'h0000_0000_A000);
    chk("t2 lane1 A1", lane_data[95:48], 48'h0000_0000_A001);
    chk("t2 lane3 A2", lane_data[191:144], 48'h0000_0000_A002);
    chk("t2 residue5", residue_cnt, 4'd5);
    send_word(mk(8'hC0));
    chk("t2 valid hold", lane_valid, 4'h0);
    chk("t2 lane0 A3", lane_data[47:0], 48'h0000_0000_A003);
    chk("t2 lane1 B0", lane_data[95:48], 48'h0000_0000_B000);
    chk("t2 lane3 B1", lane_data[191:144], 48'h0000_0000_B001);
    chk("t2 residue6", residue_cnt, 4'd6);
    step();
    chk("t2 lane0 B2", lane_data[47:0], 48'h0000_0000_B002);
    chk("t2 lane3 C0", lane_data[191:144], 48'h0000_0000_C000);
    chk("t2 residue3", residue_cnt, 4'd3);
    step();
    chk("t2 lane1 C2", lane_data[95:48], 48'h0000_0000_C002);
    chk("t2 residue0", residue_cnt, 4'd0);
    step();
    chk("t2 valid off", lane_valid, 4'h0);

    // Lane set change while residue is buffered.
    send_word(mk(8'h41));
    send_word(mk(8'h42));
    step();
    chk("t4 residue2", residue_cnt, 4'd2);
    lane_mask = 4'b0011;
    send_word(mk(8'h43));
    chk("t4 stall valid", lane_valid, 4'h0);
    chk("t4 residue6", residue_cnt, 4'd6);
    step();
    chk("t4 old mask1", lane_valid, 4'b1011);
    chk("t4 lane3 I0", lane_data[191:144], ch(8'h43, 0));
    step();
    chk("t4 old mask2", lane_valid, 4'b1011);
    chk("t4 lane3 I3", lane_data[191:144], ch(8'h43, 3));
    step();
    chk("t4 reload idle", out_idle, 1'b1);
    send_word(mk(8'h44));
    step();
    chk("t4 new mask", lane_valid, 4'b0011);
    chk("t4 lanes J0J1", lane_data[95:0], {ch(8'h44, 1), ch(8'h44, 0)});
    chk("t4 lane3 held", lane_data[191:144], ch(8'h43, 3));
    chk("t4 residue2b", residue_cnt, 4'd2);
    step();
    chk("t4 lanes J2J3", lane_data[95:0], {ch(8'h44, 3), ch(8'h44, 2)});

    // Clock qualifier low with five chunks buffered.
    lane_mask = 4'b1011;
    step();
    send_word(mk(8'h51));
    send_word(mk(8'h52));
    in_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5 frozen valid", lane_valid, 4'h0);
      chk("t5 frozen residue", residue_cnt, 4'd5);
      chk("t5 frozen idle", out_idle, 1'b0);
    end
    in_enable = 1'b1;
    step();
    chk("t5 resume valid", lane_valid, 4'b1011);
    chk("t5 resume lane0", lane_data[47:0], ch(8'h51, 3));
    chk("t5 resume lane3", lane_data[191:144], ch(8'h52, 1));
    chk("t5 resume residue", residue_cnt, 4'd2);
    send_word(mk(8'h53));
    repeat (3) step();
    chk("t5 drained", residue_cnt, 4'd0);

    // Single lane: back-pressure engages above four chunks.
    lane_mask = 4'b0001;
    step();
    send_word(mk(8'h31));
    send_word(mk(8'h32));
    chk("t3 residue7", residue_cnt, 4'd7);
    chk("t3 backpressure", out_idle, 1'b0);
    send_word(mk(8'h33));
    send_word(mk(8'h34));
    repeat (12) step();
    chk("t3 drained", residue_cnt, 4'd0);
    chk("t3 last chunk", lane_data[47:0], ch(8'h34, 3));
    chk("t3 overflow", overflow_err, 1'b0);

    // Asynchronous reset between edges with three chunks buffered.
    send_word(mk(8'h61));
    step();
    chk("t6 pre valid", lane_valid, 4'b0001);
    chk("t6 pre residue", residue_cnt, 4'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6 async valid", lane_valid, 4'h0);
    chk("t6 async residue", residue_cnt, 4'd0);
    chk("t6 async data", lane_data, 192'h0);
    #2 reset = 1'b0;
    step();
    send_word(mk(8'h71));
    step();
    chk("t6 post valid", lane_valid, 4'b0001);
    chk("t6 post lane0", lane_data[47:0], ch(8'h71, 0));
    chk("t6 post residue", residue_cnt, 4'd3);
    repeat (4) step();
    chk("t6 post drained", residue_cnt, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
